mdu_div_ctrl: RTL and testbench



---
 rtl/mdu_div_ctrl.sv | 144 ++++++++++++++
 tb/tb_mdu_div_ctrl.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_div_ctrl.sv
// Issue/return controller for the radix-2 divider: launches DIV/DIVU/REM/REMU,
// returns results with back-pressure, caches the last clean result and drains on flush.
module mdu_div_ctrl #(
  parameter int XLEN = 32,
  parameter int RD_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_rs1,
  input  logic [XLEN-1:0] req_rs2,
  input  logic [RD_W-1:0] req_rd,
  input  logic            flush,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_data,
  output logic [RD_W-1:0] resp_rd,
  output logic            resp_exception,
  output logic [XLEN-1:0] div_dividend,
  output logic [XLEN-1:0] div_divisor,
  output logic [1:0]      div_type,
  output logic            div_in_valid,
  output logic            div_cpu_busy,
  input  logic [XLEN-1:0] div_out,
  input  logic            div_out_valid,
  input  logic            div_busy,
  input  logic            div_exception,
  output logic [2:0]      dbg_state
);
  // Handshakes: a request or response transfers in a cycle where valid and ready
  // are both 1; flush withdraws valid/ready in the cycle it is asserted.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_DRAIN = 3'd3,
    S_HIT   = 3'd4
  } state_t;

  state_t            state;
  logic [1:0]        type_q;
  logic [XLEN-1:0]   rs1_q;
  logic [XLEN-1:0]   rs2_q;
  logic [RD_W-1:0]   rd_q;
  logic              cache_vld;
  logic [1:0]        cache_type;
  logic [XLEN-1:0]   cache_rs1;
  logic [XLEN-1:0]   cache_rs2;
  logic [XLEN-1:0]   cache_data;
  logic              accept;
  logic              cache_hit;
  logic              unused_funct3_bit;

  assign unused_funct3_bit = req_funct3[2];
  assign accept    = req_valid & req_ready;
  assign cache_hit = cache_vld && (cache_type == req_funct3[1:0]) &&
                     (cache_rs1 == req_rs1) && (cache_rs2 == req_rs2);

  assign div_dividend = rs1_q;
  assign div_divisor  = rs2_q;
  assign div_type     = type_q;
  assign resp_rd      = rd_q;
  assign dbg_state    = state;

  always_comb begin
    req_ready      = 1'b0;
    resp_valid     = 1'b0;
    div_in_valid   = 1'b0;
    div_cpu_busy   = 1'b0;
    resp_data      = '0;
    resp_exception = 1'b0;
    case (state)
      S_IDLE:  req_ready = !flush;
      S_ISSUE: div_in_valid = !div_busy && !flush;
      S_WAIT: begin
        resp_valid     = div_out_valid && !flush;
        resp_data      = div_out;
        resp_exception = div_exception;
        // Holding div_cpu_busy keeps the divider parked on its result until taken.
        div_cpu_busy   = !resp_ready && !flush;
      end
      S_HIT: begin
        resp_valid = !flush;
        resp_data  = cache_data;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      type_q     <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      rd_q       <= '0;
      cache_vld  <= 1'b0;
      cache_type <= '0;
      cache_rs1  <= '0;
      cache_rs2  <= '0;
      cache_data <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            type_q <= req_funct3[1:0];
            rs1_q  <= req_rs1;
            rs2_q  <= req_rs2;
            rd_q   <= req_rd;
            state  <= cache_hit ? S_HIT : S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (flush) state <= S_IDLE;
          else if (!div_busy) state <= S_WAIT;
        end
        S_WAIT: begin
          if (flush) begin
            // A result already present is released by dropping div_cpu_busy.
            state <= div_out_valid ? S_IDLE : S_DRAIN;
          end else if (div_out_valid && resp_ready) begin
            state <= S_IDLE;
            if (!div_exception) begin
              cache_vld  <= 1'b1;
              cache_type <= type_q;
              cache_rs1  <= rs1_q;
              cache_rs2  <= rs2_q;
              cache_data <= div_out;
            end
          end
        end
        S_DRAIN: begin
          if (div_out_valid) state <= S_IDLE;
        end
        S_HIT: begin
          if (flush || resp_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mdu_div_ctrl.sv
// Bench for mdu_div_ctrl: behavioural radix-2 divider stand-in plus directed and
// randomized scenarios checked against RISC-V division arithmetic and timing.
module tb_mdu_div_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_funct3;
  logic [31:0] req_rs1;
  logic [31:0] req_rs2;
  logic [4:0]  req_rd;
  logic        flush;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;
  logic [4:0]  resp_rd;
  logic        resp_exception;
  logic [31:0] div_dividend;
  logic [31:0] div_divisor;
  logic [1:0]  div_type;
  logic        div_in_valid;
  logic        div_cpu_busy;
  logic [31:0] div_out;
  logic        div_out_valid;
  logic        div_busy;
  logic        div_exception;
  logic [2:0]  dbg_state;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int launches = 0;

  mdu_div_ctrl #(.XLEN(32), .RD_W(5)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_funct3(req_funct3),
    .req_rs1(req_rs1), .req_rs2(req_rs2), .req_rd(req_rd),
    .flush(flush),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_rd(resp_rd), .resp_exception(resp_exception),
    .div_dividend(div_dividend), .div_divisor(div_divisor), .div_type(div_type),
    .div_in_valid(div_in_valid), .div_cpu_busy(div_cpu_busy),
    .div_out(div_out), .div_out_valid(div_out_valid), .div_busy(div_busy),
    .div_exception(div_exception),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- reference arithmetic ----------------
  function automatic logic ref_exc(input logic [1:0] ty, input logic [31:0] a, input logic [31:0] b);
    if (b == 32'd0) return 1'b1;
    if (!ty[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] ref_res(input logic [1:0] ty, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    sa = a;
    sb = b;
    if (b == 32'd0) return ty[1] ? a : 32'hFFFF_FFFF;
    if (!ty[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return ty[1] ? 32'd0 : 32'h8000_0000;
    case (ty)
      2'b00:   return sa / sb;
      2'b01:   return a / b;
      2'b10:   return sa % sb;
      default: return a % b;
    endcase
  endfunction

  // ---------------- divider stand-in ----------------
  // Normal ops finish 36 cycles after launch, exceptions 2; the done state is
  // held while div_cpu_busy is high.
  logic        dv_active;
  logic        dv_done;
  int          dv_cnt;
  logic [31:0] dv_res;
  logic        dv_exc;
  logic [31:0] last_dd;
  logic [31:0] last_dv;
  logic [1:0]  last_ty;

  assign div_busy      = dv_active | dv_done;
  assign div_out_valid = dv_done;
  assign div_out       = dv_done ? dv_res : 32'hDEAD_BEEF;
  assign div_exception = dv_done & dv_exc;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      dv_active <= 1'b0;
      dv_done   <= 1'b0;
      dv_cnt    <= 0;
      dv_res    <= 32'd0;
      dv_exc    <= 1'b0;
    end else if (dv_active) begin
      if (dv_cnt == 1) begin
        dv_active <= 1'b0;
        dv_done   <= 1'b1;
      end
      dv_cnt <= dv_cnt - 1;
    end else if (dv_done) begin
      if (!div_cpu_busy) dv_done <= 1'b0;
    end else if (div_in_valid) begin
      dv_active <= 1'b1;
      dv_exc    <= ref_exc(div_type, div_dividend, div_divisor);
      dv_res    <= ref_res(div_type, div_dividend, div_divisor);
      dv_cnt    <= ref_exc(div_type, div_dividend, div_divisor) ? 1 : 35;
      last_dd   <= div_dividend;
      last_dv   <= div_divisor;
      last_ty   <= div_type;
    end
  end

  always @(posedge clk) if (!rst && div_in_valid) launches <= launches + 1;

  // ---------------- driver tasks ----------------
  task automatic pulse_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // One request with resp_ready=1; returns what came back and when.
  task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, output logic [31:0] data, output logic exc,
                       output logic [4:0] rdo, output int lat, output int nl,
                       output logic acc, output logic rdy_at_resp);
    int t0;
    int l0;
    int n;
    l0 = launches;
    req_valid = 1'b1; req_funct3 = f3; req_rs1 = a; req_rs2 = b; req_rd = rd;
    resp_ready = 1'b1;
    @(negedge clk);
    acc = req_ready;
    t0 = cyc;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_rs1 = $urandom; req_rs2 = $urandom;
    req_rd = 5'($urandom); req_funct3 = 3'($urandom);
    n = 0;
    @(negedge clk);
    while (!resp_valid && n < 200) begin
      n++;
      @(negedge clk);
    end
    lat = resp_valid ? (cyc - t0) : -1;
    data = resp_data;
    exc = resp_exception;
    rdo = resp_rd;
    rdy_at_resp = req_ready;
    @(posedge clk); #1;
    nl = launches - l0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
    total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL reset_resp_valid: got %b want 0", resp_valid); end
    total++; if (div_in_valid !== 1'b0) begin bad++; $display("FAIL reset_div_in_valid: got %b want 0", div_in_valid); end
    total++; if (div_cpu_busy !== 1'b0) begin bad++; $display("FAIL reset_div_cpu_busy: got %b want 0", div_cpu_busy); end
    total++; if (dbg_state !== 3'd0) begin bad++; $display("FAIL reset_state: got %0d want 0 (idle)", dbg_state); end
    total++; if (resp_rd !== 5'd0) begin bad++; $display("FAIL reset_resp_rd: got %0d want 0", resp_rd); end
    total++; if (div_dividend !== 32'd0 || div_divisor !== 32'd0 || div_type !== 2'd0) begin
      bad++; $display("FAIL reset_div_operands: got %h %h %0d want 0 0 0", div_dividend, div_divisor, div_type); end
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic test_div_basic();
    logic [31:0] d; logic e; logic [4:0] r; int lat; int nl; logic acc; logic rr;
    do_op(3'b000, 32'd100, 32'd7, 5'd9, d, e, r, lat, nl, acc, rr);
    total++; if (acc !== 1'b1) begin bad++; $display("FAIL div_accept: got %b want 1", acc); end
    total++; if (lat != 37) begin bad++; $display("FAIL div_latency: got %0d want 37", lat); end
    total++; if (d !== 32'd14) begin bad++; $display("FAIL div_data: got %0d want 14", d); end
    total++; if (e !== 1'b0) begin bad++; $display("FAIL div_exc: got %b want 0", e); end
    total++; if (r !== 5'd9) begin bad++; $display("FAIL div_rd: got %0d want 9", r); end
    total++; if (nl != 1) begin bad++; $display("FAIL div_launches: got %0d want 1", nl); end
    total++; if (last_dd !== 32'd100 || last_dv !== 32'd7 || last_ty !== 2'b00) begin
      bad++; $display("FAIL div_operands: got %0d %0d %0d want 100 7 0", last_dd, last_dv, last_ty); end
    total++; if (rr !== 1'b0) begin bad++; $display("FAIL div_ready_at_resp: got %b want 0", rr); end
  endtask

  task automatic test_cache_hit();
    logic [31:0] d; logic e; logic [4:0] r; int lat; int nl; logic acc; logic rr;
    do_op(3'b110, 32'hFFFF_FFF9, 32'd2, 5'd17, d, e, r, lat, nl, acc, rr);
    total++; if (lat != 37) begin bad++; $display("FAIL rem_latency: got %0d want 37", lat); end
    total++; if (d !== 32'hFFFF_FFFF) begin bad++; $display("FAIL rem_data: got %h want ffffffff", d); end
    total++; if (last_ty !== 2'b10) begin bad++; $display("FAIL rem_type: got %0d want 2", last_ty); end
    do_op(3'b010, 32'hFFFF_FFF9, 32'd2, 5'd21, d, e, r, lat, nl, acc, rr);
    total++; if (lat != 1) begin bad++; $display("FAIL hit_latency: got %0d want 1", lat); end
    total++; if (d !== 32'hFFFF_FFFF) begin bad++; $display("FAIL hit_data: got %h want ffffffff", d); end
    total++; if (nl != 0) begin bad++; $display("FAIL hit_launches: got %0d want 0", nl); end
    total++; if (r !== 5'd21) begin bad++; $display("FAIL hit_rd: got %0d want 21", r); end
    total++; if (e !== 1'b0) begin bad++; $display("FAIL hit_exc: got %b want 0", e); end
  endtask

  task automatic test_exception();
    logic [31:0] d; logic e; logic [4:0] r; int lat; int nl; logic acc; logic rr;
    do_op(3'b101, 32'd5, 32'd0, 5'd2, d, e, r, lat, nl, acc, rr);
    total++; if (lat != 3) begin bad++; $display("FAIL divz_latency: got %0d want 3", lat); end
    total++; if (d !== 32'hFFFF_FFFF) begin bad++; $display("FAIL divz_data: got %h want ffffffff", d); end
    total++; if (e !== 1'b1) begin bad++; $display("FAIL divz_exc: got %b want 1", e); end
    do_op(3'b101, 32'd5, 32'd0, 5'd2, d, e, r, lat, nl, acc, rr);
    total++; if (lat != 3) begin bad++; $display("FAIL divz_again_latency: got %0d want 3", lat); end
    total++; if (nl != 1) begin bad++; $display("FAIL divz_again_launches: got %0d want 1", nl); end
    total++; if (e !== 1'b1) begin bad++; $display("FAIL divz_again_exc: got %b want 1", e); end
    do_op(3'b011, 32'd5, 32'd0, 5'd3, d, e, r, lat, nl, acc, rr);
    total++; if (d !== 32'd5 || e !== 1'b1) begin bad++; $display("FAIL remz: got %h/%b want 5/1", d, e); end
    do_op(3'b000, 32'h8000_0000, 32'hFFFF_FFFF, 5'd6, d, e, r, lat, nl, acc, rr);
    total++; if (lat != 3) begin bad++; $display("FAIL ovf_latency: got %0d want 3", lat); end
    total++; if (d !== 32'h8000_0000 || e !== 1'b1) begin bad++; $display("FAIL ovf: got %h/%b want 80000000/1", d, e); end
  endtask

  task automatic test_backpressure();
    int t0; int n;
    req_valid = 1'b1; req_funct3 = 3'b000; req_rs1 = 32'd1000; req_rs2 = 32'd10; req_rd = 5'd3;
    resp_ready = 1'b0;
    @(negedge clk);
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL bp_accept: got %b want 1", req_ready); end
    t0 = cyc;
    @(posedge clk); #1;
    req_valid = 1'b0; req_rs1 = $urandom; req_rd = 5'($urandom);
    n = 0;
    @(negedge clk);
    while (!resp_valid && n < 200) begin n++; @(negedge clk); end
    total++; if (cyc - t0 != 37) begin bad++; $display("FAIL bp_latency: got %0d want 37", cyc - t0); end
    for (int i = 0; i < 5; i++) begin
      total++; if (resp_valid !== 1'b1 || resp_data !== 32'd100 || resp_rd !== 5'd3) begin
        bad++; $display("FAIL bp_hold_%0d: got v=%b d=%0d rd=%0d want 1 100 3", i, resp_valid, resp_data, resp_rd); end
      total++; if (div_cpu_busy !== 1'b1) begin bad++; $display("FAIL bp_cpu_busy_%0d: got %b want 1", i, div_cpu_busy); end
      @(posedge clk); #1;
      if (i == 4) resp_ready = 1'b1;
      @(negedge clk);
    end
    total++; if (resp_valid !== 1'b1 || resp_data !== 32'd100) begin
      bad++; $display("FAIL bp_handshake: got v=%b d=%0d want 1 100", resp_valid, resp_data); end
    total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL bp_ready_same_cycle: got %b want 0", req_ready); end
    @(posedge clk); #1;
    @(negedge clk);
    total++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      bad++; $display("FAIL bp_after: got rdy=%b v=%b want 1 0", req_ready, resp_valid); end
  endtask

  task automatic test_flush();
    logic [31:0] d; logic e; logic [4:0] r; int lat; int nl; logic acc; logic rr; int l0;
    // flush while idle blocks acceptance
    @(posedge clk); #1;
    flush = 1'b1; req_valid = 1'b1; req_funct3 = 3'b000; req_rs1 = 32'd1; req_rs2 = 32'd1;
    @(negedge clk);
    total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL flush_idle_ready: got %b want 0", req_ready); end
    @(posedge clk); #1;
    flush = 1'b0; req_valid = 1'b0;
    // flush in the launch cycle
    req_valid = 1'b1; req_funct3 = 3'b001; req_rs1 = 32'd9; req_rs2 = 32'd3; req_rd = 5'd7;
    @(negedge clk);
    @(posedge clk); #1;
    req_valid = 1'b0; flush = 1'b1; l0 = launches;
    @(negedge clk);
    total++; if (div_in_valid !== 1'b0) begin bad++; $display("FAIL flush_issue_launch: got %b want 0", div_in_valid); end
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    total++; if (req_ready !== 1'b1 || launches != l0) begin
      bad++; $display("FAIL flush_issue_idle: got rdy=%b launches=%0d want 1 %0d", req_ready, launches, l0); end
    // flush mid-division: drain
    @(posedge clk); #1;
    resp_ready = 1'b0;
    req_valid = 1'b1;
    @(negedge clk);
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL drain_accept: got %b want 1", req_ready); end
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int k = 1; k <= 38; k++) begin
      flush = (k == 10) || (k == 20);
      @(negedge clk);
      total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL drain_resp_valid_T%0d: got %b want 0", k, resp_valid); end
      if (k >= 11 && k <= 37) begin
        total++; if (req_ready !== 1'b0 || div_cpu_busy !== 1'b0) begin
          bad++; $display("FAIL drain_T%0d: got rdy=%b cpu_busy=%b want 0 0", k, req_ready, div_cpu_busy); end
      end
      if (k == 37) begin
        total++; if (div_out_valid !== 1'b1) begin bad++; $display("FAIL drain_div_done: got %b want 1", div_out_valid); end
      end
      if (k == 38) begin
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL drain_idle: got %b want 1", req_ready); end
      end
      @(posedge clk); #1;
    end
    flush = 1'b0;
    do_op(3'b000, 32'd1000, 32'd10, 5'd4, d, e, r, lat, nl, acc, rr);
    total++; if (lat != 1 || d !== 32'd100) begin bad++; $display("FAIL cache_kept: got lat=%0d d=%0d want 1 100", lat, d); end
    do_op(3'b001, 32'd9, 32'd3, 5'd7, d, e, r, lat, nl, acc, rr);
    total++; if (lat != 37 || d !== 32'd3) begin bad++; $display("FAIL drain_not_cached: got lat=%0d d=%0d want 37 3", lat, d); end
  endtask

  task automatic test_flush_on_done();
    logic [31:0] d; logic e; logic [4:0] r; int lat; int nl; logic acc; logic rr; int n;
    req_valid = 1'b1; req_funct3 = 3'b000; req_rs1 = 32'd50; req_rs2 = 32'd5; req_rd = 5'd4;
    resp_ready = 1'b0;
    @(negedge clk);
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = 0;
    @(negedge clk);
    while (!resp_valid && n < 200) begin n++; @(negedge clk); end
    @(posedge clk); #1;
    flush = 1'b1;
    @(negedge clk);
    total++; if (resp_valid !== 1'b0 || div_cpu_busy !== 1'b0 || div_out_valid !== 1'b1) begin
      bad++; $display("FAIL flush_done: got v=%b cpu_busy=%b dov=%b want 0 0 1", resp_valid, div_cpu_busy, div_out_valid); end
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    total++; if (div_busy !== 1'b0 || req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      bad++; $display("FAIL flush_done_after: got div_busy=%b rdy=%b v=%b want 0 1 0", div_busy, req_ready, resp_valid); end
    @(posedge clk); #1;
    do_op(3'b000, 32'd50, 32'd5, 5'd4, d, e, r, lat, nl, acc, rr);
    total++; if (lat != 37 || d !== 32'd10) begin bad++; $display("FAIL flush_done_not_cached: got lat=%0d d=%0d want 37 10", lat, d); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d; logic e; logic [4:0] r; int lat; int nl; logic acc; logic rr;
    req_valid = 1'b1; req_funct3 = 3'b000; req_rs1 = 32'd77; req_rs2 = 32'd7; req_rd = 5'd1;
    @(negedge clk);
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    total++; if (req_ready !== 1'b1 || resp_valid !== 1'b0 || dbg_state !== 3'd0) begin
      bad++; $display("FAIL reset_mid: got rdy=%b v=%b st=%0d want 1 0 0", req_ready, resp_valid, dbg_state); end
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    total++; if (div_busy !== 1'b0) begin bad++; $display("FAIL reset_mid_div_idle: got %b want 0", div_busy); end
    @(posedge clk); #1;
    do_op(3'b000, 32'd1000, 32'd10, 5'd4, d, e, r, lat, nl, acc, rr);
    total++; if (lat != 37 || d !== 32'd100) begin bad++; $display("FAIL reset_clears_cache: got lat=%0d d=%0d want 37 100", lat, d); end
  endtask

  task automatic test_random();
    logic [31:0] d; logic e; logic [4:0] r; int lat; int nl; logic acc; logic rr;
    logic c_vld; logic [1:0] c_ty; logic [31:0] c_a; logic [31:0] c_b;
    logic [2:0] f3; logic [31:0] a; logic [31:0] b; logic [4:0] rd;
    logic hit; logic x_exc; logic [31:0] x_res; int x_lat;
    logic [1:0] exp_q[$];
    pulse_reset();
    c_vld = 1'b0; c_ty = 2'd0; c_a = 32'd0; c_b = 32'd0;
    f3 = 3'd0; a = 32'd1; b = 32'd1;
    for (int i = 0; i < 30; i++) begin
      case ($urandom_range(0, 5))
        0: begin f3 = 3'($urandom); a = $urandom; b = 32'd0; end
        1: begin f3 = {1'b0, 1'($urandom), 1'b0}; a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: f3 = {1'($urandom), f3[1:0]};
        3: begin f3 = 3'($urandom); a = $urandom_range(0, 1000); b = $urandom_range(1, 40); end
        default: begin f3 = 3'($urandom); a = $urandom; b = $urandom; end
      endcase
      rd = 5'($urandom);
      hit = c_vld && c_ty == f3[1:0] && c_a == a && c_b == b;
      x_exc = hit ? 1'b0 : ref_exc(f3[1:0], a, b);
      x_res = ref_res(f3[1:0], a, b);
      x_lat = hit ? 1 : (x_exc ? 3 : 37);
      do_op(f3, a, b, rd, d, e, r, lat, nl, acc, rr);
      total++; if (d !== x_res || e !== x_exc || r !== rd) begin
        bad++; $display("FAIL rnd%0d_result: got %h/%b/%0d want %h/%b/%0d", i, d, e, r, x_res, x_exc, rd); end
      total++; if (lat != x_lat || nl != (hit ? 0 : 1)) begin
        bad++; $display("FAIL rnd%0d_timing: got lat=%0d launches=%0d want %0d %0d", i, lat, nl, x_lat, hit ? 0 : 1); end
      if (!hit) exp_q.push_back(f3[1:0]);
      if (!hit && exp_q.size() > 0) begin
        total++; if (last_dd !== a || last_dv !== b || last_ty !== exp_q.pop_front()) begin
          bad++; $display("FAIL rnd%0d_operands: got %h %h %0d want %h %h %0d", i, last_dd, last_dv, last_ty, a, b, f3[1:0]); end
      end
      if (!x_exc) begin c_vld = 1'b1; c_ty = f3[1:0]; c_a = a; c_b = b; end
    end
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_funct3 = 3'd0; req_rs1 = 32'd0; req_rs2 = 32'd0;
    req_rd = 5'd0; flush = 1'b0; resp_ready = 1'b0;
    test_reset();
    test_div_basic();
    test_cache_hit();
    test_exception();
    test_backpressure();
    test_flush();
    test_flush_on_done();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
